arm_top: RTL and testbench



---
 rtl/arm_pkg.sv | 74 +++++++
 rtl/arm_core.sv | 141 ++++++++++++++
 rtl/arm_top.sv | 53 +++++
 tb/tb_arm_top.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// arm_pkg
// Shared encodings for the single-cycle ARM-subset processor:
//   - instruction op field values (data processing, memory, branch)
//   - data-processing cmd codes that the core implements
//   - the fifteen condition codes (1111 never passes)
//   - ALU control encoding
//   - word width and memory depth
//   - cond_pass(): evaluates a condition code against the NZCV flags
package arm_pkg;

    localparam int WORD_W    = 32;
    localparam int MEM_DEPTH = 64;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_e;

    // Flags are packed as {N, Z, C, V}; any code outside the table
    // (only 1111 remains) never passes.
    function automatic logic cond_pass(input logic [3:0] cond,
                                       input logic [3:0] nzcv);
        logic n, z, c, v, pass;
        {n, z, c, v} = nzcv;
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/arm_core.sv
// arm_core
// Single-cycle datapath and control: PC, register file R0-R14, decoder,
// condition check, ALU and NZCV flags. Memories live in the parent.
// Ports:
//   i_clk        clock, state commits on the rising edge
//   i_rst        asynchronous active-high reset, clears PC and flags
//   i_instr      instruction fetched at o_pc
//   i_read_data  data-memory word at o_alu_result
//   o_pc         current program counter
//   o_alu_result ALU result, doubles as the data-memory address
//   o_write_data Rd value, the store data for STR
//   o_mem_write  STR whose condition passes
module arm_core
    import arm_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [WORD_W-1:0] i_instr,
    input  logic [WORD_W-1:0] i_read_data,
    output logic [WORD_W-1:0] o_pc,
    output logic [WORD_W-1:0] o_alu_result,
    output logic [WORD_W-1:0] o_write_data,
    output logic              o_mem_write
);

    logic [WORD_W-1:0] r_pc;
    logic [3:0]        r_nzcv;
    logic [WORD_W-1:0] r_regs [0:14];

    logic [3:0]  w_cond, w_cmd, w_rn, w_rd, w_rm, w_src2;
    logic [1:0]  w_op;
    logic        w_imm_sel, w_s_bit;
    logic [WORD_W-1:0] w_pc_plus4, w_pc_plus8, w_rd1, w_rd2, w_src_b;
    logic [WORD_W-1:0] w_b_eff, w_result, w_br_target;
    logic [WORD_W:0]   w_sum;
    alu_ctrl_e   w_alu_ctrl;
    logic        w_dp_valid, w_is_logic, w_is_mem, w_is_br, w_cond_ok;
    logic        w_sub, w_flag_c, w_flag_v;
    logic        w_reg_write, w_flag_write, w_branch;

    assign w_cond    = i_instr[31:28];
    assign w_op      = i_instr[27:26];
    assign w_imm_sel = i_instr[25];
    assign w_cmd     = i_instr[24:21];
    assign w_s_bit   = i_instr[20];
    assign w_rn      = i_instr[19:16];
    assign w_rd      = i_instr[15:12];
    assign w_rm      = i_instr[3:0];

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_plus8 = r_pc + 32'd8;

    // The second read port serves Rd for stores and Rm otherwise;
    // R15 on either port reads as PC+8.
    assign w_src2 = (w_op == OP_MEM) ? w_rd : w_rm;
    assign w_rd1  = (w_rn   == 4'hF) ? w_pc_plus8 : r_regs[w_rn];
    assign w_rd2  = (w_src2 == 4'hF) ? w_pc_plus8 : r_regs[w_src2];

    assign w_is_mem = (w_op == OP_MEM);
    assign w_is_br  = (w_op == OP_BR);

    // Decode the ALU operation. Memory ops add the offset to Rn; any
    // data-processing cmd outside the supported four is left invalid so
    // that it changes nothing.
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        w_dp_valid = 1'b0;
        w_is_logic = 1'b0;
        if (w_op == OP_DP) begin
            case (w_cmd)
                CMD_ADD: begin w_alu_ctrl = ALU_ADD; w_dp_valid = 1'b1; end
                CMD_SUB: begin w_alu_ctrl = ALU_SUB; w_dp_valid = 1'b1; end
                CMD_AND: begin w_alu_ctrl = ALU_AND; w_dp_valid = 1'b1; w_is_logic = 1'b1; end
                CMD_ORR: begin w_alu_ctrl = ALU_ORR; w_dp_valid = 1'b1; w_is_logic = 1'b1; end
                default: w_alu_ctrl = ALU_ADD;
            endcase
        end
    end

    assign w_src_b = w_is_mem  ? {20'd0, i_instr[11:0]} :
                     w_imm_sel ? {24'd0, i_instr[7:0]}  : w_rd2;

    // Subtraction is A + ~B + 1 so the carry out of the 33-bit sum is the
    // ARM "not borrow" C flag for both ADD and SUB.
    assign w_sub   = (w_alu_ctrl == ALU_SUB);
    assign w_b_eff = w_sub ? ~w_src_b : w_src_b;
    assign w_sum   = {1'b0, w_rd1} + {1'b0, w_b_eff} + {{WORD_W{1'b0}}, w_sub};

    always_comb begin
        w_result = w_sum[WORD_W-1:0];
        case (w_alu_ctrl)
            ALU_AND: w_result = w_rd1 & w_src_b;
            ALU_ORR: w_result = w_rd1 | w_src_b;
            default: w_result = w_sum[WORD_W-1:0];
        endcase
    end

    assign w_flag_c = ~w_is_logic & w_sum[WORD_W];
    assign w_flag_v = ~w_is_logic & (w_rd1[WORD_W-1] == w_b_eff[WORD_W-1]) &
                      (w_sum[WORD_W-1] != w_rd1[WORD_W-1]);

    // Every architectural side effect is gated by the condition check.
    assign w_cond_ok    = cond_pass(w_cond, r_nzcv);
    assign w_reg_write  = w_cond_ok & (w_dp_valid | (w_is_mem & w_s_bit)) & (w_rd != 4'hF);
    assign o_mem_write  = w_cond_ok & w_is_mem & ~w_s_bit;
    assign w_flag_write = w_cond_ok & w_dp_valid & w_s_bit;
    assign w_branch     = w_cond_ok & w_is_br;
    assign w_br_target  = w_pc_plus8 + {{6{i_instr[23]}}, i_instr[23:0], 2'b00};

    // PC and flags reset asynchronously. Logic ops with S set update
    // only N and Z, leaving C and V from the last arithmetic op.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc   <= '0;
            r_nzcv <= '0;
        end else begin
            r_pc <= w_branch ? w_br_target : w_pc_plus4;
            if (w_flag_write) begin
                r_nzcv[3] <= w_result[WORD_W-1];
                r_nzcv[2] <= (w_result == '0);
                if (!w_is_logic) begin
                    r_nzcv[1] <= w_flag_c;
                    r_nzcv[0] <= w_flag_v;
                end
            end
        end
    end

    // Register file keeps its contents across reset; loads take the
    // memory word, everything else the ALU result.
    always_ff @(posedge i_clk) begin
        if (w_reg_write) begin
            r_regs[w_rd] <= w_is_mem ? i_read_data : w_result;
        end
    end

    assign o_pc         = r_pc;
    assign o_alu_result = w_result;
    assign o_write_data = w_rd2;

endmodule

// File: rtl/arm_top.sv
// arm_top
// Single-cycle ARM-subset processor: arm_core plus 64-word instruction
// memory and 64-word data memory.
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset
//   WriteData  store data (Rd value for STR)
//   DataAdr    data-memory address (ALU result)
//   MemWrite   store strobe, held low while reset is high
module arm_top
    import arm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic [WORD_W-1:0] WriteData,
    output logic [WORD_W-1:0] DataAdr,
    output logic              MemWrite
);

    logic [WORD_W-1:0] r_imem [0:MEM_DEPTH-1];
    logic [WORD_W-1:0] r_dmem [0:MEM_DEPTH-1] = '{default: '0};

    logic [WORD_W-1:0] w_pc, w_instr, w_read_data;
    logic              w_core_mem_write;
    logic              w_unused;

    // Both memories index by word and wrap modulo their depth; the
    // instruction ROM is only ever read here.
    assign w_instr     = r_imem[w_pc[7:2]];
    assign w_read_data = r_dmem[DataAdr[7:2]];
    assign MemWrite    = w_core_mem_write & ~reset;

    // Stores commit on the same edge as the rest of the instruction.
    always_ff @(posedge clk) begin
        if (MemWrite) begin
            r_dmem[DataAdr[7:2]] <= WriteData;
        end
    end

    arm_core u_core (
        .i_clk        (clk),
        .i_rst        (reset),
        .i_instr      (w_instr),
        .i_read_data  (w_read_data),
        .o_pc         (w_pc),
        .o_alu_result (DataAdr),
        .o_write_data (WriteData),
        .o_mem_write  (w_core_mem_write)
    );

    assign w_unused = ^{w_pc[31:8], w_pc[1:0], DataAdr[31:8], DataAdr[1:0]};

endmodule

// File: tb/tb_arm_top.sv
// tb_arm_top
// Directed programs are written into the instruction ROM, and every store
// the processor makes is matched against a queue of expected stores.
module tb_arm_top;

    localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_GE = 4'hA, C_LT = 4'hB;
    localparam logic [3:0] C_AL = 4'hE, C_NV = 4'hF;
    localparam logic [3:0] K_AND = 4'b0000, K_SUB = 4'b0010;
    localparam logic [3:0] K_ADD = 4'b0100, K_ORR = 4'b1100;
    localparam logic [31:0] FILLER = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] WriteData, DataAdr;
    logic        MemWrite;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } store_t;

    store_t      sbQueue[$];
    logic [31:0] progWords [0:63];
    int          checkCount = 0;
    int          passCount  = 0;
    int          failCount  = 0;

    arm_top dut (
        .clk       (clk),
        .reset     (reset),
        .WriteData (WriteData),
        .DataAdr   (DataAdr),
        .MemWrite  (MemWrite)
    );

    always #5 clk = ~clk;

    // Instruction encoders
    function automatic logic [31:0] dpImm(input logic [3:0] cond, input logic [3:0] cmd,
                                          input logic s, input logic [3:0] rn,
                                          input logic [3:0] rd, input logic [7:0] imm);
        return {cond, 2'b00, 1'b1, cmd, s, rn, rd, 4'h0, imm};
    endfunction

    function automatic logic [31:0] dpReg(input logic [3:0] cond, input logic [3:0] cmd,
                                          input logic s, input logic [3:0] rn,
                                          input logic [3:0] rd, input logic [3:0] rm);
        return {cond, 2'b00, 1'b0, cmd, s, rn, rd, 8'h00, rm};
    endfunction

    function automatic logic [31:0] memOp(input logic [3:0] cond, input logic l,
                                          input logic [3:0] rn, input logic [3:0] rd,
                                          input logic [11:0] imm);
        return {cond, 2'b01, 5'b01100, l, rn, rd, imm};
    endfunction

    function automatic logic [31:0] brOp(input logic [3:0] cond, input logic [23:0] imm);
        return {cond, 2'b10, 2'b10, imm};
    endfunction

    // One comparison: counts it, and reports tag/observed/expected on a miss
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic expectStore(input logic [31:0] adr, input logic [31:0] data);
        store_t s;
        s.adr  = adr;
        s.data = data;
        sbQueue.push_back(s);
    endtask

    task automatic clearProgram();
        for (int i = 0; i < 64; i++) progWords[i] = FILLER;
    endtask

    task automatic loadProgram();
        for (int i = 0; i < 64; i++) dut.r_imem[i] = progWords[i];
    endtask

    // Asynchronous reset mid-cycle, reload the ROM, release off the edge
    task automatic applyStimulus();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset pc", dut.u_core.r_pc, 32'd0);
        checkOutput("async reset nzcv", {28'd0, dut.u_core.r_nzcv}, 32'd0);
        checkOutput("memwrite in reset", {31'd0, MemWrite}, 32'd0);
        loadProgram();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic runAndDrain(input int cycles, input string tag);
        repeat (cycles) @(negedge clk);
        checkOutput(tag, sbQueue.size(), 32'd0);
        sbQueue.delete();
    endtask

    // Store monitor: samples 1 ns before each rising edge
    always begin
        @(negedge clk);
        #4;
        if (!reset && MemWrite) begin
            checkOutput("store was expected", {31'd0, sbQueue.size() != 0}, 32'd1);
            if (sbQueue.size() != 0) begin
                store_t s;
                s = sbQueue.pop_front();
                checkOutput("store address", DataAdr, s.adr);
                checkOutput("store data", WriteData, s.data);
            end
        end
    end

    initial begin
        // Reset from time 0; instruction 0 stores PC+8 at PC+8
        clearProgram();
        progWords[0] = memOp(C_AL, 1'b0, 4'hF, 4'hF, 12'd0);
        #1 loadProgram();
        expectStore(32'd8, 32'd8);
        #13;
        checkOutput("reset pc", dut.u_core.r_pc, 32'd0);
        checkOutput("reset memwrite", {31'd0, MemWrite}, 32'd0);
        checkOutput("reset nzcv", {28'd0, dut.u_core.r_nzcv}, 32'd0);
        #8 reset = 1'b0;
        runAndDrain(4, "first fetch store seen");

        // Self-check program
        clearProgram();
        progWords[0]  = dpReg(C_AL, K_SUB, 1'b0, 4'hF, 4'd0, 4'hF);
        progWords[1]  = dpImm(C_AL, K_ADD, 1'b0, 4'd0, 4'd2, 8'd5);
        progWords[2]  = dpImm(C_AL, K_ADD, 1'b0, 4'd0, 4'd3, 8'd12);
        progWords[3]  = dpImm(C_AL, K_SUB, 1'b0, 4'd3, 4'd7, 8'd9);
        progWords[4]  = dpReg(C_AL, K_ORR, 1'b0, 4'd7, 4'd4, 4'd2);
        progWords[5]  = dpReg(C_AL, K_AND, 1'b0, 4'd3, 4'd5, 4'd4);
        progWords[6]  = dpReg(C_AL, K_ADD, 1'b0, 4'd5, 4'd5, 4'd4);
        progWords[7]  = dpReg(C_AL, K_SUB, 1'b1, 4'd5, 4'd8, 4'd7);
        progWords[8]  = brOp(C_EQ, 24'd10);
        progWords[9]  = dpReg(C_AL, K_SUB, 1'b1, 4'd3, 4'd8, 4'd4);
        progWords[10] = brOp(C_GE, 24'd0);
        progWords[11] = dpImm(C_AL, K_ADD, 1'b0, 4'd0, 4'd5, 8'd0);
        progWords[12] = dpReg(C_AL, K_SUB, 1'b1, 4'd7, 4'd8, 4'd2);
        progWords[13] = dpImm(C_LT, K_ADD, 1'b0, 4'd5, 4'd7, 8'd1);
        progWords[14] = dpReg(C_AL, K_SUB, 1'b0, 4'd7, 4'd7, 4'd2);
        progWords[15] = memOp(C_AL, 1'b0, 4'd3, 4'd7, 12'd84);
        progWords[16] = memOp(C_AL, 1'b1, 4'd0, 4'd2, 12'd96);
        progWords[17] = brOp(C_AL, 24'd1);
        progWords[18] = dpImm(C_AL, K_ADD, 1'b0, 4'd0, 4'd2, 8'd13);
        progWords[19] = dpImm(C_AL, K_ADD, 1'b0, 4'd0, 4'd2, 8'd10);
        progWords[20] = memOp(C_AL, 1'b0, 4'd0, 4'd2, 12'd100);
        expectStore(32'd96, 32'd7);
        expectStore(32'd100, 32'd7);
        applyStimulus();
        runAndDrain(26, "self-check stores seen");

        // ADD, ADD, STR
        clearProgram();
        progWords[0] = dpReg(C_AL, K_SUB, 1'b0, 4'hF, 4'd0, 4'hF);
        progWords[1] = dpImm(C_AL, K_ADD, 1'b0, 4'd0, 4'd1, 8'd5);
        progWords[2] = dpImm(C_AL, K_ADD, 1'b0, 4'd1, 4'd2, 8'd2);
        progWords[3] = memOp(C_AL, 1'b0, 4'd0, 4'd2, 12'd8);
        expectStore(32'd8, 32'd7);
        applyStimulus();
        runAndDrain(7, "add chain store seen");

        // SUBS sets Z, NE/EQ pick the EQ value, NV store is suppressed
        clearProgram();
        progWords[0] = dpReg(C_AL, K_SUB, 1'b0, 4'hF, 4'd0, 4'hF);
        progWords[1] = dpImm(C_AL, K_ADD, 1'b0, 4'd0, 4'd1, 8'd5);
        progWords[2] = dpReg(C_AL, K_SUB, 1'b1, 4'd1, 4'd3, 4'd1);
        progWords[3] = dpImm(C_NE, K_ADD, 1'b0, 4'd0, 4'd4, 8'd1);
        progWords[4] = dpImm(C_EQ, K_ADD, 1'b0, 4'd0, 4'd4, 8'd9);
        progWords[5] = memOp(C_AL, 1'b0, 4'd0, 4'd4, 12'd0);
        progWords[6] = memOp(C_NV, 1'b0, 4'd0, 4'd1, 12'd32);
        expectStore(32'd0, 32'd9);
        applyStimulus();
        runAndDrain(10, "conditional store seen");
        checkOutput("subs nzcv", {28'd0, dut.u_core.r_nzcv}, 32'h6);

        // Branch over a store of 0xFF
        clearProgram();
        progWords[0] = dpReg(C_AL, K_SUB, 1'b0, 4'hF, 4'd0, 4'hF);
        progWords[1] = dpImm(C_AL, K_ADD, 1'b0, 4'd0, 4'd1, 8'hFF);
        progWords[2] = brOp(C_AL, 24'd0);
        progWords[3] = memOp(C_AL, 1'b0, 4'd0, 4'd1, 12'd0);
        progWords[4] = dpImm(C_AL, K_ADD, 1'b0, 4'd0, 4'd2, 8'h33);
        progWords[5] = memOp(C_AL, 1'b0, 4'd0, 4'd2, 12'd4);
        expectStore(32'd4, 32'h33);
        applyStimulus();
        runAndDrain(9, "branch target store seen");

        // Address wrap, load-use, logic op keeps C
        clearProgram();
        progWords[0] = dpReg(C_AL, K_SUB, 1'b0, 4'hF, 4'd0, 4'hF);
        progWords[1] = dpImm(C_AL, K_ADD, 1'b0, 4'd0, 4'd1, 8'h12);
        progWords[2] = memOp(C_AL, 1'b0, 4'd0, 4'd1, 12'd260);
        progWords[3] = memOp(C_AL, 1'b1, 4'd0, 4'd5, 12'd4);
        progWords[4] = memOp(C_AL, 1'b0, 4'd0, 4'd5, 12'd16);
        progWords[5] = dpReg(C_AL, K_SUB, 1'b1, 4'd1, 4'd6, 4'd0);
        progWords[6] = dpImm(C_AL, K_AND, 1'b1, 4'd1, 4'd7, 8'd0);
        expectStore(32'd260, 32'h12);
        expectStore(32'd16, 32'h12);
        applyStimulus();
        runAndDrain(10, "wrap stores seen");
        checkOutput("ands keeps carry", {28'd0, dut.u_core.r_nzcv}, 32'h6);

        $display("[TB] %0d failing comparisons", failCount);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
